// File: rtl/ctrl_burst_data.sv
// ctrl_burst_data -- data-phase stage behind the CAS controller.
// Each accepted CAS command is queued with the timestamp at which its data
// window opens (issue time + AL+CL for reads, AL+CWL for writes). When the
// head comes due, a BL/2-clock window is driven. The last beat of the window
// raises rw_done.
// Optional feature: define WR_DQS_PREAMBLE_EN to add the dqs_oe output.
// That output gives a one-clock write DQS preamble and covers every write window.
module ctrl_burst_data #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 6
) (
  input  logic       CK_t,
  input  logic       reset_n,
  input  logic       cas_rdy,
  input  logic [2:0] cas_req,
  input  logic [4:0] CL,
  input  logic [4:0] AL,
  input  logic [4:0] CWL,
  input  logic [3:0] BL,
  output logic       rd_valid,
  output logic       wr_en,
  output logic [2:0] beat_idx,
  output logic [2:0] burst_req,
  output logic       rw_done,
  output logic       data_busy,
  output logic       ovf_err,
  output logic       col_err
`ifdef WR_DQS_PREAMBLE_EN
  ,
  output logic       dqs_oe
`endif
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CNT_W = PW + 1;

  // Request codes shared with the CAS controller (ddr_pkg encoding).
  localparam logic [2:0] RD_R  = 3'd2;
  localparam logic [2:0] RDA_R = 3'd3;
  localparam logic [2:0] WR_R  = 3'd4;
  localparam logic [2:0] WRA_R = 3'd5;

  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_WAIT  = 2'd1,
    D_BURST = 2'd2
  } state_t;

  state_t           state;
  logic [TS_W-1:0]  ts;

  // Pending-burst queue: request code plus the timestamp its window opens.
  logic [2:0]       q_req [DEPTH];
  logic [TS_W-1:0]  q_due [DEPTH];
  logic [PW-1:0]    q_rd;
  logic [PW-1:0]    q_wr;
  logic [CNT_W-1:0] q_cnt;

  function automatic logic is_data_req(input logic [2:0] r);
    return (r == RD_R) || (r == RDA_R) || (r == WR_R) || (r == WRA_R);
  endfunction

  function automatic logic is_write_req(input logic [2:0] r);
    return (r == WR_R) || (r == WRA_R);
  endfunction

  logic             q_empty;
  logic             q_full;
  logic [2:0]       head_req;
  logic [TS_W-1:0]  head_due;
  logic             head_hit;
  logic [2:0]       last_idx;
  logic             last_beat;
  logic             cmd_ok;
  logic             push;
  logic             pop;
  logic             start;
  logic             collide;
  logic             burst_next;
  logic [2:0]       beat_next;
  logic [2:0]       req_next;
  logic [CNT_W-1:0] cnt_next;
  logic [TS_W-1:0]  lat;
  logic [TS_W-1:0]  push_due;
  logic [TS_W-1:0]  ts_inc;

  // Queue status, due detection and next-window decisions for this edge.
  always_comb begin
    q_empty   = (q_cnt == '0);
    q_full    = (q_cnt == CNT_W'(DEPTH));
    head_req  = q_req[q_rd];
    head_due  = q_due[q_rd];
    ts_inc    = ts + 1'b1;
    last_idx  = 3'((BL >> 1) - 4'd1);
    last_beat = (state == D_BURST) && (beat_idx == last_idx);

    // Latency is chosen by the incoming command type; due wraps modulo 2**TS_W.
    if (is_write_req(cas_req)) lat = TS_W'(AL) + TS_W'(CWL);
    else                       lat = TS_W'(AL) + TS_W'(CL);
    push_due = ts + lat;

    cmd_ok   = cas_rdy && is_data_req(cas_req);
    // A full queue rejects the push even if the head pops on the same edge.
    push     = cmd_ok && !q_full;
    head_hit = !q_empty && (head_due == ts);
    pop      = head_hit;

    // A due head opens a window unless a window is mid-flight; on the last
    // beat it chains seamlessly, otherwise it is discarded as a collision.
    start    = head_hit && ((state != D_BURST) || last_beat);
    collide  = head_hit && (state == D_BURST) && !last_beat;

    burst_next = start || ((state == D_BURST) && !last_beat);
    beat_next  = start ? 3'd0 : (beat_idx + 3'd1);
    req_next   = start ? head_req : burst_req;
    cnt_next   = q_cnt + CNT_W'(push) - CNT_W'(pop);
  end

`ifdef WR_DQS_PREAMBLE_EN
  logic [PW-1:0]   q_rd_nxt;
  logic            nh_valid;
  logic [2:0]      nh_req;
  logic [TS_W-1:0] nh_due;
  logic            dqs_next;

  // Look at the queue head as it will stand after this edge; a write due on
  // the following edge needs its DQS preamble now.
  always_comb begin
    q_rd_nxt = q_rd + PW'(1);
    nh_valid = 1'b0;
    nh_req   = cas_req;
    nh_due   = push_due;
    if (pop) begin
      if (q_cnt > CNT_W'(1)) begin
        nh_valid = 1'b1;
        nh_req   = q_req[q_rd_nxt];
        nh_due   = q_due[q_rd_nxt];
      end else begin
        nh_valid = push;
      end
    end else if (!q_empty) begin
      nh_valid = 1'b1;
      nh_req   = head_req;
      nh_due   = head_due;
    end else begin
      nh_valid = push;
    end
    dqs_next = (burst_next && is_write_req(req_next)) ||
               (nh_valid && is_write_req(nh_req) && (nh_due == ts_inc));
  end
`endif

  // Queue storage: payload only, no reset needed since q_cnt qualifies it.
  always_ff @(posedge CK_t) begin
    if (push) begin
      q_req[q_wr] <= cas_req;
      q_due[q_wr] <= push_due;
    end
  end

  // Timestamp, queue pointers, data-phase FSM and registered outputs.
  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      state     <= D_IDLE;
      ts        <= '0;
      q_rd      <= '0;
      q_wr      <= '0;
      q_cnt     <= '0;
      rd_valid  <= 1'b0;
      wr_en     <= 1'b0;
      beat_idx  <= 3'd0;
      burst_req <= 3'd0;
      rw_done   <= 1'b0;
      data_busy <= 1'b0;
      ovf_err   <= 1'b0;
      col_err   <= 1'b0;
`ifdef WR_DQS_PREAMBLE_EN
      dqs_oe    <= 1'b0;
`endif
    end else begin
      ts    <= ts_inc;
      q_cnt <= cnt_next;
      if (push) q_wr <= q_wr + PW'(1);
      if (pop)  q_rd <= q_rd + PW'(1);

      if (burst_next)          state <= D_BURST;
      else if (cnt_next != '0) state <= D_WAIT;
      else                     state <= D_IDLE;

      rd_valid  <= burst_next && !is_write_req(req_next);
      wr_en     <= burst_next && is_write_req(req_next);
      beat_idx  <= burst_next ? beat_next : 3'd0;
      burst_req <= burst_next ? req_next : 3'd0;
      rw_done   <= burst_next && (beat_next == last_idx);
      data_busy <= burst_next || (cnt_next != '0);

      if (cmd_ok && q_full) ovf_err <= 1'b1;
      if (collide)          col_err <= 1'b1;
`ifdef WR_DQS_PREAMBLE_EN
      dqs_oe    <= dqs_next;
`endif
    end
  end

endmodule

// File: tb/tb_ctrl_burst_data.sv
// tb_ctrl_burst_data -- directed and randomized stimulus for ctrl_burst_data.
// The reference model tracks pending bursts as absolute cycle numbers. It
// also tracks the current window as a [start, start+BL/2) interval.
module tb_ctrl_burst_data;

  localparam int DEPTH = 4;
  localparam logic [2:0] RD_R  = 3'd2;
  localparam logic [2:0] RDA_R = 3'd3;
  localparam logic [2:0] WR_R  = 3'd4;
  localparam logic [2:0] WRA_R = 3'd5;

  logic       CK_t    = 1'b0;
  logic       reset_n = 1'b0;
  logic       cas_rdy = 1'b0;
  logic [2:0] cas_req = 3'd0;
  logic [4:0] CL, AL, CWL;
  logic [3:0] BL;
  logic       rd_valid, wr_en, rw_done, data_busy, ovf_err, col_err;
  logic [2:0] beat_idx, burst_req;
`ifdef WR_DQS_PREAMBLE_EN
  logic       dqs_oe;
`endif

  ctrl_burst_data #(.DEPTH(DEPTH), .TS_W(6)) dut (
    .CK_t(CK_t), .reset_n(reset_n), .cas_rdy(cas_rdy), .cas_req(cas_req),
    .CL(CL), .AL(AL), .CWL(CWL), .BL(BL),
    .rd_valid(rd_valid), .wr_en(wr_en), .beat_idx(beat_idx), .burst_req(burst_req),
    .rw_done(rw_done), .data_busy(data_busy), .ovf_err(ovf_err), .col_err(col_err)
`ifdef WR_DQS_PREAMBLE_EN
    , .dqs_oe(dqs_oe)
`endif
  );

  always #5 CK_t = ~CK_t;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] req;
    int         due;
  } ent_t;

  ent_t       q[$];
  int         cyc = 0;
  int         ws = -100;
  logic [2:0] wreq = 3'd0;
  logic       ovf_m = 1'b0;
  logic       col_m = 1'b0;
  int         done_seen = 0;
  int         cl_v, al_v, cwl_v, bl_v;

  function automatic logic m_valid(input logic [2:0] r);
    return (r == RD_R) || (r == RDA_R) || (r == WR_R) || (r == WRA_R);
  endfunction

  function automatic logic m_write(input logic [2:0] r);
    return (r == WR_R) || (r == WRA_R);
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at cyc %0d: got %b want %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at cyc %0d: got %0d want %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic set_timing(input int cl, input int al, input int cwl, input int bl);
    cl_v = cl; al_v = al; cwl_v = cwl; bl_v = bl;
    CL = 5'(cl); AL = 5'(al); CWL = 5'(cwl); BL = 4'(bl);
  endtask

  // Compare every output against the model's view of the current cycle.
  task automatic check_all(input string ph);
    logic occ;
    logic pre;
    occ = (cyc >= ws) && (cyc < ws + bl_v / 2);
    pre = (q.size() > 0) && m_write(q[0].req) && (q[0].due == cyc + 1);
    chk1({ph, ".rd_valid"},  rd_valid,  occ && !m_write(wreq));
    chk1({ph, ".wr_en"},     wr_en,     occ && m_write(wreq));
    chk3({ph, ".beat_idx"},  beat_idx,  occ ? 3'(cyc - ws) : 3'd0);
    chk3({ph, ".burst_req"}, burst_req, occ ? wreq : 3'd0);
    chk1({ph, ".rw_done"},   rw_done,   occ && (cyc == ws + bl_v / 2 - 1));
    chk1({ph, ".data_busy"}, data_busy, occ || (q.size() > 0));
    chk1({ph, ".ovf_err"},   ovf_err,   ovf_m);
    chk1({ph, ".col_err"},   col_err,   col_m);
`ifdef WR_DQS_PREAMBLE_EN
    chk1({ph, ".dqs_oe"},    dqs_oe,    (occ && m_write(wreq)) || pre);
`else
    if (pre) chk1({ph, ".pre_ignored"}, 1'b0, 1'b0 | rd_valid & 1'b0);
`endif
    if (rw_done === 1'b1) done_seen++;
  endtask

  // One clock: drive inputs, take the edge, advance the model, check.
  task automatic step(input logic rdy, input logic [2:0] req);
    logic full;
    cas_rdy = rdy;
    cas_req = req;
    @(posedge CK_t);
    full = (q.size() == DEPTH);
    if ((q.size() > 0) && (q[0].due == cyc)) begin
      if ((cyc >= ws) && (cyc <= ws + bl_v / 2 - 1)) col_m = 1'b1;
      else begin
        ws   = cyc;
        wreq = q[0].req;
      end
      void'(q.pop_front());
    end
    if (rdy && m_valid(req)) begin
      if (full) ovf_m = 1'b1;
      else q.push_back('{req: req, due: cyc + al_v + (m_write(req) ? cwl_v : cl_v)});
    end
    #1;
    check_all("step");
    cyc++;
    cas_rdy = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0);
  endtask

  // Asynchronous reset asserted between edges, held for two edges.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    q.delete();
    ws = -100; ovf_m = 1'b0; col_m = 1'b0;
    check_all("async_rst");
    for (int i = 0; i < 2; i++) begin
      @(posedge CK_t);
      cyc++;
    end
    #4 reset_n = 1'b1;
  endtask

  task automatic rand_seg(input int n);
    int         last_due;
    int         due;
    logic [2:0] r;
    last_due = cyc;
    for (int i = 0; i < n; i++) begin
      r   = 3'($urandom_range(0, 7));
      due = cyc + al_v + (m_write(r) ? cwl_v : cl_v);
      if (($urandom_range(0, 3) == 0) && (due > last_due)) begin
        if (m_valid(r)) last_due = due;
        step(1'b1, r);
      end else begin
        step(1'b0, 3'($urandom_range(0, 7)));
      end
    end
    idle(40);
  endtask

  initial begin
    set_timing(11, 0, 9, 8);
    #3;
    check_all("reset");
    for (int i = 0; i < 2; i++) begin
      @(posedge CK_t);
      cyc++;
    end
    #4 reset_n = 1'b1;

    // Single read, then single write with auto-precharge.
    step(1'b1, RD_R);  idle(18);
    step(1'b1, WRA_R); idle(16);

    // Reads four clocks apart chain into one continuous window.
    step(1'b1, RD_R); idle(3); step(1'b1, RD_R); idle(20);

    // Long CL: the fifth command finds the queue full.
    set_timing(24, 0, 9, 8);
    done_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, RD_R);
      idle(3);
    end
    idle(40);
    chk_int("ovf_windows", done_seen, 4);
    chk1("ovf_sticky", ovf_err, 1'b1);
    do_reset();
    set_timing(11, 0, 9, 8);

    // Reads two clocks apart: the second collides and is discarded.
    done_seen = 0;
    step(1'b1, RD_R); idle(1); step(1'b1, RD_R); idle(20);
    chk_int("col_windows", done_seen, 1);
    chk1("col_sticky", col_err, 1'b1);
    do_reset();

    // Reset in the middle of a read window, then a fresh read.
    step(1'b1, RD_R); idle(12);
    do_reset();
    step(1'b1, RD_R); idle(18);

    // Non-data codes with cas_rdy are ignored.
    step(1'b1, 3'd0); step(1'b1, 3'd7); step(1'b1, 3'd1); idle(3);

    // BL=4 with AL: read then write chained seamlessly.
    set_timing(7, 2, 5, 4);
    step(1'b1, RD_R); idle(3); step(1'b1, WR_R); idle(15);

    // Randomized traffic across several timestamp wraps.
    rand_seg(300);
    do_reset();
    set_timing(11, 0, 9, 8);
    rand_seg(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
